// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-fed RAM: command encodings carried in the
// top two bits of each received word.
// Pure declarations, no logic.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    localparam int CMD_W = 2;

endpackage

// File: rtl/spi_ram.sv
// Small register-array RAM driven by command words from an SPI slave front end.
// Latency: read data and tx_valid appear one clock after the read-data command.
// Backpressure: none; every qualified word is consumed on the edge it is seen.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 8,
    parameter int ADDR_SIZE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_SIZE+1:0]   din,
    input  logic                   rx_valid,
    output logic [ADDR_SIZE-1:0]   dout,
    output logic                   tx_valid
);

    // Refuse to build with an address too narrow for the depth.
    if (ADDR_SIZE < 1 || MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_bad_params
        $error("spi_ram: need ADDR_SIZE >= 1 and 1 <= MEM_DEPTH <= 2**ADDR_SIZE");
    end

    // One extra bit so a depth of exactly 2**ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0] DEPTH_LIM = MEM_DEPTH[ADDR_SIZE:0];

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 wr_in_range;
    logic                 rd_in_range;

    assign cmd         = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload     = din[ADDR_SIZE-1:0];
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

    // Command decode, storage and registered read port; reset wins over any command.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            dout     <= '0;
            tx_valid <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload;
                    CMD_WR_DATA: begin
                        // Writes beyond the populated depth are dropped.
                        if (wr_in_range) begin
                            mem[wr_addr] <= payload;
                        end
                    end
                    CMD_RD_ADDR: rd_addr <= payload;
                    CMD_RD_DATA: begin
                        // Reads beyond the populated depth return zero but still handshake.
                        dout     <= rd_in_range ? mem[rd_addr] : '0;
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Bench for spi_ram: a full-depth instance and a depth-6 instance share stimulus
// and are compared every cycle against a behavioural model of each.
module tb_spi_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] din;
    logic       rx_valid;
    logic [2:0] dout_a, dout_b;
    logic       tx_a, tx_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_ram #(.MEM_DEPTH(8), .ADDR_SIZE(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_a), .tx_valid(tx_a)
    );

    spi_ram #(.MEM_DEPTH(6), .ADDR_SIZE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_b), .tx_valid(tx_b)
    );

    // Behavioural model: index 0 is depth 8, index 1 is depth 6.
    int depth [2] = '{8, 6};
    int mdl_mem [2][8];
    int mdl_wa [2];
    int mdl_ra [2];
    int mdl_dout [2];
    int mdl_tx [2];
    bit checking = 0;

    always @(posedge clk) begin
        int cmd, p;
        cmd = int'(din[4:3]);
        p   = int'(din[2:0]);
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                for (int i = 0; i < 8; i++) mdl_mem[k][i] = 0;
                mdl_wa[k] = 0; mdl_ra[k] = 0; mdl_dout[k] = 0; mdl_tx[k] = 0;
            end else begin
                mdl_tx[k] = 0;
                if (rx_valid) begin
                    if (cmd == 0) mdl_wa[k] = p;
                    else if (cmd == 1) begin
                        if (mdl_wa[k] < depth[k]) mdl_mem[k][mdl_wa[k]] = p;
                    end else if (cmd == 2) mdl_ra[k] = p;
                    else begin
                        mdl_dout[k] = (mdl_ra[k] < depth[k]) ? mdl_mem[k][mdl_ra[k]] : 0;
                        mdl_tx[k]   = 1;
                    end
                end
            end
        end
        if (rst_n) checking = 1;
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                int ad, at;
                ad = (k == 0) ? int'(dout_a) : int'(dout_b);
                at = (k == 0) ? int'(tx_a) : int'(tx_b);
                checks++;
                if (ad !== mdl_dout[k]) begin
                    errors++;
                    $display("FAIL model_dout[d%0d] t=%0t: got %0d expected %0d", depth[k], $time, ad, mdl_dout[k]);
                end
                checks++;
                if (at !== mdl_tx[k]) begin
                    errors++;
                    $display("FAIL model_tx[d%0d] t=%0t: got %0d expected %0d", depth[k], $time, at, mdl_tx[k]);
                end
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one word, return after the following falling edge (outputs settled).
    task automatic step(input bit r, input bit v, input logic [4:0] d);
        rst_n = r; rx_valid = v; din = d;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; rx_valid = 1'b0; din = '0;

        step(1, 0, 5'b00_000);
        step(1, 0, 5'b00_000);
        lit("reset_dout", int'(dout_a), 0);
        lit("reset_tx",   int'(tx_a),   0);

        step(0, 0, 5'b00_110);
        step(0, 0, 5'b00_110);
        lit("idle_dout", int'(dout_a), 0);
        lit("idle_tx",   int'(tx_a),   0);

        step(0, 1, 5'b00_110);
        step(0, 1, 5'b01_111);
        step(0, 1, 5'b00_100);
        step(0, 1, 5'b01_010);
        lit("write_tx_low", int'(tx_a), 0);

        step(0, 0, 5'b10_110);
        step(0, 1, 5'b10_110);
        step(0, 1, 5'b11_001);
        lit("read6_dout",   int'(dout_a), 7);
        lit("read6_tx",     int'(tx_a),   1);
        lit("d6_read6_dout", int'(dout_b), 0);
        lit("d6_read6_tx",   int'(tx_b),   1);

        step(0, 1, 5'b00_110);
        lit("hold_tx",   int'(tx_a),   0);
        lit("hold_dout", int'(dout_a), 7);
        step(0, 1, 5'b11_100);
        lit("reread_dout", int'(dout_a), 7);
        lit("reread_tx",   int'(tx_a),   1);
        step(0, 1, 5'b11_000);
        lit("b2b_tx", int'(tx_a), 1);

        step(0, 1, 5'b00_111);
        step(0, 1, 5'b01_111);
        step(0, 1, 5'b10_111);
        step(0, 1, 5'b11_000);
        lit("d6_oob_dout", int'(dout_b), 0);
        lit("d6_oob_tx",   int'(tx_b),   1);
        lit("d8_addr7_dout", int'(dout_a), 7);
        step(0, 1, 5'b10_100);
        step(0, 1, 5'b11_000);
        lit("d6_word4_dout", int'(dout_b), 2);

        step(1, 1, 5'b11_000);
        lit("midreset_dout", int'(dout_a), 0);
        lit("midreset_tx",   int'(tx_a),   0);
        step(0, 1, 5'b10_110);
        step(0, 1, 5'b11_000);
        lit("post_reset_dout", int'(dout_a), 0);
        lit("post_reset_tx",   int'(tx_a),   1);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)));
        end
        step(0, 0, 5'b00_000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 8, number of memory words.
REQ-002 Parameter ADDR_SIZE, default 3, address width; also data-word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-high (asserted when 1); name kept per codebase convention.
REQ-005 din  input  ADDR_SIZE+2  command/payload word: din[ADDR_SIZE+1:ADDR_SIZE] = command, din[ADDR_SIZE-1:0] = payload.
REQ-006 rx_valid  input  1  din qualifier; din ignored when 0.
REQ-007 dout  output  ADDR_SIZE  registered read data.
REQ-008 tx_valid  output  1  registered; high for exactly the cycle after a read-data command.

Function
REQ-009 Storage SHALL be MEM_DEPTH words of ADDR_SIZE bits, single port, with an internal write-address register and a separate read-address register.
REQ-010 A command SHALL be accepted only on a rising edge where rx_valid=1 and rst_n=0; with rx_valid=0, memory, address registers and dout SHALL hold and tx_valid SHALL be 0.
REQ-011 Command 00 (write address): wr_addr <= payload.
REQ-012 Command 01 (write data): mem[wr_addr] <= payload; wr_addr unchanged.
REQ-013 Command 10 (read address): rd_addr <= payload.
REQ-014 Command 11 (read data): dout <= mem[rd_addr], tx_valid <= 1; payload ignored; rd_addr unchanged.
REQ-015 Latency: dout/tx_valid SHALL reflect a read-data command one clock after the accepting edge; no combinational din-to-dout path.
REQ-016 tx_valid SHALL be 0 after any edge not accepting command 11; back-to-back command 11 cycles keep tx_valid high.
REQ-017 dout SHALL hold its last value until the next accepted command 11.
REQ-018 Read data SHALL reflect the memory state before the same edge (no bypass; only one command per cycle, so no same-edge conflict).
REQ-019 Addresses >= MEM_DEPTH: write data SHALL be discarded; read data SHALL return 0; tx_valid still asserted.
REQ-020 Addresses SHALL persist indefinitely; repeated writes/reads to the same address need no re-send of an address command.

Reset
REQ-021 While rst_n=1 at a rising edge: dout=0, tx_valid=0, wr_addr=0, rd_addr=0, all memory words=0.
REQ-022 Reset SHALL override any command on the same edge; a command issued during reset is lost.

Structure
REQ-023 A shared package SHALL hold the 2-bit command encodings (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11).
REQ-024 Single module; no sub-module needed. Storage SHALL be one register array indexed by the address registers.
REQ-025 Parameters SHALL be checked at elaboration: MEM_DEPTH <= 2**ADDR_SIZE, ADDR_SIZE >= 1.

Verification
REQ-026 Reset 2 cycles, then din=00_110 with rx_valid=0 for 2 cycles -> no state change, dout=0, tx_valid=0.
REQ-027 rx_valid=1: 00_110, 01_111, 00_100, 01_010 -> mem[6]=7, mem[4]=2, tx_valid stays 0.
REQ-028 10_110 with rx_valid=0, then rx_valid=1 -> rd_addr=6; then 11_001 -> next cycle dout=7, tx_valid=1.
REQ-029 Following 00_110 -> tx_valid=0, dout holds 7; then 11_100 -> dout=7 (rd_addr still 6), tx_valid=1.
REQ-030 Assert reset mid-sequence with 11_xxx on din -> dout=0, tx_valid=0, all reads afterwards return 0.
REQ-031 MEM_DEPTH=6: write 7 to address 7, read address 7 -> dout=0, tx_valid=1, words 0..5 unchanged.
